// File: rtl/axi_rr_arbiter.sv
// AXI channel types plus a round-robin arbiter that shares one AXI subordinate
// port between NB_MANAGERS managers, with independent write and read locks.
package axi_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_aw_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;
endpackage

// state   | meaning
// W_IDLE  | no write owner; arbitrate on awvalid
// W_AW    | AW passthrough for wgrant
// W_DATA  | W passthrough for wgrant until last beat
// W_RESP  | B routed back to wgrant
// R_IDLE  | no read owner; arbitrate on arvalid
// R_ADDR  | AR passthrough for rgrant
// R_DATA  | R routed back to rgrant until last beat
module axi_rr_arbiter
  import axi_pkg::*;
#(
  parameter int NB_MANAGERS = 4,
  parameter int GRANT_W     = $clog2(NB_MANAGERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  axi_aw_t [NB_MANAGERS-1:0]      i_axi_m_aw,
  input  logic    [NB_MANAGERS-1:0]      i_axi_m_awvalid,
  output logic    [NB_MANAGERS-1:0]      o_axi_m_awready,
  input  axi_w_t  [NB_MANAGERS-1:0]      i_axi_m_w,
  input  logic    [NB_MANAGERS-1:0]      i_axi_m_wvalid,
  output logic    [NB_MANAGERS-1:0]      o_axi_m_wready,
  output axi_b_t  [NB_MANAGERS-1:0]      o_axi_m_b,
  output logic    [NB_MANAGERS-1:0]      o_axi_m_bvalid,
  input  logic    [NB_MANAGERS-1:0]      i_axi_m_bready,
  input  axi_ar_t [NB_MANAGERS-1:0]      i_axi_m_ar,
  input  logic    [NB_MANAGERS-1:0]      i_axi_m_arvalid,
  output logic    [NB_MANAGERS-1:0]      o_axi_m_arready,
  output axi_r_t  [NB_MANAGERS-1:0]      o_axi_m_r,
  output logic    [NB_MANAGERS-1:0]      o_axi_m_rvalid,
  input  logic    [NB_MANAGERS-1:0]      i_axi_m_rready,
  output axi_aw_t                        o_axi_s_aw,
  output logic                           o_axi_s_awvalid,
  input  logic                           i_axi_s_awready,
  output axi_w_t                         o_axi_s_w,
  output logic                           o_axi_s_wvalid,
  input  logic                           i_axi_s_wready,
  input  axi_b_t                         i_axi_s_b,
  input  logic                           i_axi_s_bvalid,
  output logic                           o_axi_s_bready,
  output axi_ar_t                        o_axi_s_ar,
  output logic                           o_axi_s_arvalid,
  input  logic                           i_axi_s_arready,
  input  axi_r_t                         i_axi_s_r,
  input  logic                           i_axi_s_rvalid,
  output logic                           o_axi_s_rready
);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;
  logic [GRANT_W-1:0] wgrant, wgrant_nxt, wlast_grant, wlast_nxt;
  logic [GRANT_W-1:0] rgrant, rgrant_nxt, rlast_grant, rlast_nxt;

  // First requester after the previous owner, wrapping modulo NB_MANAGERS.
  function automatic logic [GRANT_W-1:0] rr_pick(input logic [NB_MANAGERS-1:0] req,
                                                 input logic [GRANT_W-1:0] last);
    logic [GRANT_W-1:0] pick;
    logic [GRANT_W-1:0] sel;
    logic               found;
    int                 idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NB_MANAGERS; k++) begin
      idx = (int'(last) + k) % NB_MANAGERS;
      sel = GRANT_W'(idx);
      if (!found && req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate      <= W_IDLE;
      wgrant      <= '0;
      wlast_grant <= GRANT_W'(NB_MANAGERS - 1);
      rstate      <= R_IDLE;
      rgrant      <= '0;
      rlast_grant <= GRANT_W'(NB_MANAGERS - 1);
    end else begin
      wstate      <= wstate_nxt;
      wgrant      <= wgrant_nxt;
      wlast_grant <= wlast_nxt;
      rstate      <= rstate_nxt;
      rgrant      <= rgrant_nxt;
      rlast_grant <= rlast_nxt;
    end
  end

  always_comb begin
    wstate_nxt      = wstate;
    wgrant_nxt      = wgrant;
    wlast_nxt       = wlast_grant;
    o_axi_s_aw      = i_axi_m_aw[wgrant];
    o_axi_s_awvalid = 1'b0;
    o_axi_m_awready = '0;
    o_axi_s_w       = i_axi_m_w[wgrant];
    o_axi_s_wvalid  = 1'b0;
    o_axi_m_wready  = '0;
    o_axi_m_bvalid  = '0;
    o_axi_s_bready  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (|i_axi_m_awvalid) begin
          wgrant_nxt = rr_pick(i_axi_m_awvalid, wlast_grant);
          wstate_nxt = W_AW;
        end
      end
      W_AW: begin
        o_axi_s_awvalid         = i_axi_m_awvalid[wgrant];
        o_axi_m_awready[wgrant] = i_axi_s_awready;
        if (i_axi_m_awvalid[wgrant] && i_axi_s_awready) wstate_nxt = W_DATA;
      end
      W_DATA: begin
        o_axi_s_wvalid         = i_axi_m_wvalid[wgrant];
        o_axi_m_wready[wgrant] = i_axi_s_wready;
        if (i_axi_m_wvalid[wgrant] && i_axi_s_wready && i_axi_m_w[wgrant].last)
          wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_axi_m_bvalid[wgrant] = i_axi_s_bvalid;
        o_axi_s_bready         = i_axi_m_bready[wgrant];
        if (i_axi_s_bvalid && i_axi_m_bready[wgrant]) begin
          wlast_nxt  = wgrant;
          wstate_nxt = W_IDLE;
        end
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_nxt      = rstate;
    rgrant_nxt      = rgrant;
    rlast_nxt       = rlast_grant;
    o_axi_s_ar      = i_axi_m_ar[rgrant];
    o_axi_s_arvalid = 1'b0;
    o_axi_m_arready = '0;
    o_axi_m_rvalid  = '0;
    o_axi_s_rready  = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (|i_axi_m_arvalid) begin
          rgrant_nxt = rr_pick(i_axi_m_arvalid, rlast_grant);
          rstate_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        o_axi_s_arvalid         = i_axi_m_arvalid[rgrant];
        o_axi_m_arready[rgrant] = i_axi_s_arready;
        if (i_axi_m_arvalid[rgrant] && i_axi_s_arready) rstate_nxt = R_DATA;
      end
      R_DATA: begin
        o_axi_m_rvalid[rgrant] = i_axi_s_rvalid;
        o_axi_s_rready         = i_axi_m_rready[rgrant];
        if (i_axi_s_rvalid && i_axi_m_rready[rgrant] && i_axi_s_r.last) begin
          rlast_nxt  = rgrant;
          rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  // Response payloads fan out to every manager; only valid is steered.
  always_comb begin
    for (int i = 0; i < NB_MANAGERS; i++) begin
      o_axi_m_b[i] = i_axi_s_b;
      o_axi_m_r[i] = i_axi_s_r;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Self-checking bench for axi_rr_arbiter: manager requests push expected grants
// into a scoreboard that is popped as the subordinate side sees each transaction.
module tb_axi_rr_arbiter;
  import axi_pkg::*;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst;

  axi_aw_t [NB-1:0] i_axi_m_aw;
  logic    [NB-1:0] i_axi_m_awvalid, o_axi_m_awready;
  axi_w_t  [NB-1:0] i_axi_m_w;
  logic    [NB-1:0] i_axi_m_wvalid, o_axi_m_wready;
  axi_b_t  [NB-1:0] o_axi_m_b;
  logic    [NB-1:0] o_axi_m_bvalid, i_axi_m_bready;
  axi_ar_t [NB-1:0] i_axi_m_ar;
  logic    [NB-1:0] i_axi_m_arvalid, o_axi_m_arready;
  axi_r_t  [NB-1:0] o_axi_m_r;
  logic    [NB-1:0] o_axi_m_rvalid, i_axi_m_rready;
  axi_aw_t o_axi_s_aw;
  logic    o_axi_s_awvalid, i_axi_s_awready;
  axi_w_t  o_axi_s_w;
  logic    o_axi_s_wvalid, i_axi_s_wready;
  axi_b_t  i_axi_s_b;
  logic    i_axi_s_bvalid, o_axi_s_bready;
  axi_ar_t o_axi_s_ar;
  logic    o_axi_s_arvalid, i_axi_s_arready;
  axi_r_t  i_axi_s_r;
  logic    i_axi_s_rvalid, o_axi_s_rready;

  axi_rr_arbiter #(.NB_MANAGERS(NB)) dut (
    .clk(clk), .rst(rst),
    .i_axi_m_aw(i_axi_m_aw), .i_axi_m_awvalid(i_axi_m_awvalid), .o_axi_m_awready(o_axi_m_awready),
    .i_axi_m_w(i_axi_m_w), .i_axi_m_wvalid(i_axi_m_wvalid), .o_axi_m_wready(o_axi_m_wready),
    .o_axi_m_b(o_axi_m_b), .o_axi_m_bvalid(o_axi_m_bvalid), .i_axi_m_bready(i_axi_m_bready),
    .i_axi_m_ar(i_axi_m_ar), .i_axi_m_arvalid(i_axi_m_arvalid), .o_axi_m_arready(o_axi_m_arready),
    .o_axi_m_r(o_axi_m_r), .o_axi_m_rvalid(o_axi_m_rvalid), .i_axi_m_rready(i_axi_m_rready),
    .o_axi_s_aw(o_axi_s_aw), .o_axi_s_awvalid(o_axi_s_awvalid), .i_axi_s_awready(i_axi_s_awready),
    .o_axi_s_w(o_axi_s_w), .o_axi_s_wvalid(o_axi_s_wvalid), .i_axi_s_wready(i_axi_s_wready),
    .i_axi_s_b(i_axi_s_b), .i_axi_s_bvalid(i_axi_s_bvalid), .o_axi_s_bready(o_axi_s_bready),
    .o_axi_s_ar(o_axi_s_ar), .o_axi_s_arvalid(o_axi_s_arvalid), .i_axi_s_arready(i_axi_s_arready),
    .i_axi_s_r(i_axi_s_r), .i_axi_s_rvalid(i_axi_s_rvalid), .o_axi_s_rready(o_axi_s_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          mgr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_vr();
    return |{o_axi_m_awready, o_axi_m_wready, o_axi_m_bvalid, o_axi_m_arready,
             o_axi_m_rvalid, o_axi_s_awvalid, o_axi_s_wvalid, o_axi_s_bready,
             o_axi_s_arvalid, o_axi_s_rready};
  endfunction

  function automatic logic [63:0] wr_data(input int m);
    return 64'hDEADBEEF_0000_0000 | 64'(m);
  endfunction

  function automatic logic [63:0] rd_data(input int m);
    return 64'hCAFE0000_5A5A_0000 | 64'(m);
  endfunction

  task automatic clear_inputs();
    for (int m = 0; m < NB; m++) begin
      i_axi_m_aw[m].id    = 4'(m);
      i_axi_m_aw[m].addr  = 32'h1000 + 32'(m * 16);
      i_axi_m_aw[m].len   = 8'd0;
      i_axi_m_aw[m].size  = 3'd3;
      i_axi_m_aw[m].burst = 2'd1;
      i_axi_m_ar[m].id    = 4'(m);
      i_axi_m_ar[m].addr  = 32'h2000 + 32'(m * 16);
      i_axi_m_ar[m].len   = 8'd0;
      i_axi_m_ar[m].size  = 3'd3;
      i_axi_m_ar[m].burst = 2'd1;
      i_axi_m_w[m].data   = wr_data(m);
      i_axi_m_w[m].strb   = 8'hFF;
      i_axi_m_w[m].last   = 1'b1;
    end
    i_axi_m_awvalid = '0; i_axi_m_wvalid = '0; i_axi_m_bready = '0;
    i_axi_m_arvalid = '0; i_axi_m_rready = '0;
    i_axi_s_awready = 1'b0; i_axi_s_wready = 1'b0; i_axi_s_arready = 1'b0;
    i_axi_s_b = '0; i_axi_s_bvalid = 1'b0;
    i_axi_s_r = '0; i_axi_s_rvalid = 1'b0;
  endtask

  // Subordinate-side model of one single-beat write; reports what it observed.
  task automatic serve_write(input int wdelay, output int gid, output int lat,
                             output logic [31:0] aw_addr, output logic [3:0] awr_mask,
                             output logic wv_early, output logic [63:0] wdata,
                             output logic [3:0] bmask, output logic [3:0] bid,
                             output logic tmo);
    logic [1:0] g;
    tmo = 1'b0; lat = 0; gid = -1; aw_addr = '0; awr_mask = '0;
    wv_early = 1'b0; wdata = '0; bmask = '0; bid = '0;
    #1;
    while (!o_axi_s_awvalid && lat < 20) begin
      step(); #1; lat++;
    end
    if (!o_axi_s_awvalid) begin
      tmo = 1'b1;
      return;
    end
    g = o_axi_s_aw.id[1:0];
    gid = int'(g);
    aw_addr = o_axi_s_aw.addr;
    i_axi_s_awready = 1'b1;
    #1 awr_mask = o_axi_m_awready;
    step();
    i_axi_s_awready = 1'b0;
    i_axi_m_awvalid[g] = 1'b0;
    repeat (wdelay) begin
      #1 wv_early = wv_early | o_axi_s_wvalid;
      step();
    end
    i_axi_m_wvalid[g] = 1'b1;
    i_axi_s_wready = 1'b1;
    #1 wdata = o_axi_s_wvalid ? o_axi_s_w.data : 64'h0;
    step();
    i_axi_m_wvalid[g] = 1'b0;
    i_axi_s_wready = 1'b0;
    i_axi_s_b.id = {2'b00, g};
    i_axi_s_b.resp = 2'b00;
    i_axi_s_bvalid = 1'b1;
    i_axi_m_bready = '1;
    #1;
    bmask = o_axi_m_bvalid;
    bid = o_axi_m_b[g].id;
    step();
    i_axi_s_bvalid = 1'b0;
    i_axi_m_bready = '0;
  endtask

  task automatic serve_read(output int gid, output logic [3:0] arr_mask,
                            output logic [3:0] rmask, output logic [63:0] rdata,
                            output logic [3:0] rid, output logic tmo);
    logic [1:0] g;
    int n;
    tmo = 1'b0; n = 0; gid = -1; arr_mask = '0; rmask = '0; rdata = '0; rid = '0;
    #1;
    while (!o_axi_s_arvalid && n < 20) begin
      step(); #1; n++;
    end
    if (!o_axi_s_arvalid) begin
      tmo = 1'b1;
      return;
    end
    g = o_axi_s_ar.id[1:0];
    gid = int'(g);
    i_axi_s_arready = 1'b1;
    #1 arr_mask = o_axi_m_arready;
    step();
    i_axi_s_arready = 1'b0;
    i_axi_m_arvalid[g] = 1'b0;
    i_axi_s_r.id = {2'b00, g};
    i_axi_s_r.data = rd_data(gid);
    i_axi_s_r.resp = 2'b00;
    i_axi_s_r.last = 1'b1;
    i_axi_s_rvalid = 1'b1;
    i_axi_m_rready = '1;
    #1;
    rmask = o_axi_m_rvalid;
    rdata = o_axi_m_r[g].data;
    rid = o_axi_m_r[g].id;
    step();
    i_axi_s_rvalid = 1'b0;
    i_axi_m_rready = '0;
  endtask

  task automatic test_reset();
    int gid, lat;
    logic [31:0] aw_addr;
    logic [3:0] awr_mask, bmask, bid;
    logic wv_early, tmo;
    logic [63:0] wdata;
    exp_t e;
    clear_inputs();
    rst = 1'b1;
    repeat (3) begin
      i_axi_m_awvalid = 4'b1101;
      step();
      checks++;
      if (any_vr() !== 1'b0) begin
        errors++; $display("FAIL reset_outputs got %b want 0", any_vr());
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (any_vr() !== 1'b0) begin
      errors++; $display("FAIL post_reset_outputs got %b want 0", any_vr());
    end
    exp_q.push_back('{0, wr_data(0)});
    exp_q.push_back('{2, wr_data(2)});
    exp_q.push_back('{3, wr_data(3)});
    for (int i = 0; i < 3; i++) begin
      serve_write(0, gid, lat, aw_addr, awr_mask, wv_early, wdata, bmask, bid, tmo);
      e = exp_q.pop_front();
      checks++;
      if (tmo) begin
        errors++; $display("FAIL reset_wr_timeout got none want mgr %0d", e.mgr);
        continue;
      end
      if (i == 0) begin
        checks++;
        if (lat !== 1) begin
          errors++; $display("FAIL first_grant_latency got %0d want 1", lat);
        end
      end
      if (gid !== e.mgr) begin
        errors++; $display("FAIL reset_wr_grant got %0d want %0d", gid, e.mgr);
      end
      checks++;
      if (awr_mask !== 4'(1 << e.mgr)) begin
        errors++; $display("FAIL reset_awready got %b want %b", awr_mask, 4'(1 << e.mgr));
      end
      checks++;
      if (wdata !== e.data) begin
        errors++; $display("FAIL reset_wdata got %h want %h", wdata, e.data);
      end
      checks++;
      if (bmask !== 4'(1 << e.mgr) || bid !== 4'(e.mgr)) begin
        errors++; $display("FAIL reset_b_route got %b/%0d want %b/%0d", bmask, bid, 4'(1 << e.mgr), e.mgr);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid;
    logic [3:0] arr_mask, rmask, rid;
    logic [63:0] rdata;
    logic tmo;
    exp_t e;
    clear_inputs();
    i_axi_m_arvalid = 4'b1111;
    exp_q.push_back('{0, rd_data(0)});
    exp_q.push_back('{1, rd_data(1)});
    exp_q.push_back('{2, rd_data(2)});
    exp_q.push_back('{3, rd_data(3)});
    exp_q.push_back('{0, rd_data(0)});
    for (int i = 0; i < 5; i++) begin
      serve_read(gid, arr_mask, rmask, rdata, rid, tmo);
      if (i == 0) i_axi_m_arvalid[0] = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if (tmo) begin
        errors++; $display("FAIL rr_timeout got none want mgr %0d", e.mgr);
        continue;
      end
      if (gid !== e.mgr) begin
        errors++; $display("FAIL rr_grant got %0d want %0d", gid, e.mgr);
      end
      checks++;
      if (arr_mask !== 4'(1 << e.mgr) || rmask !== 4'(1 << e.mgr)) begin
        errors++; $display("FAIL rr_route got ar %b r %b want %b", arr_mask, rmask, 4'(1 << e.mgr));
      end
      checks++;
      if (rdata !== e.data || rid !== 4'(e.mgr)) begin
        errors++; $display("FAIL rr_rdata got %h/%0d want %h/%0d", rdata, rid, e.data, e.mgr);
      end
    end
  endtask

  task automatic test_delayed_w();
    int gid, lat;
    logic [31:0] aw_addr;
    logic [3:0] awr_mask, bmask, bid;
    logic wv_early, tmo;
    logic [63:0] wdata;
    exp_t e;
    clear_inputs();
    i_axi_m_aw[1].addr = 32'h100;
    i_axi_m_w[1].data = 64'hDEADBEEF00000001;
    i_axi_m_awvalid[1] = 1'b1;
    exp_q.push_back('{1, 64'hDEADBEEF00000001});
    serve_write(5, gid, lat, aw_addr, awr_mask, wv_early, wdata, bmask, bid, tmo);
    e = exp_q.pop_front();
    checks++;
    if (tmo || gid !== e.mgr || aw_addr !== 32'h100) begin
      errors++; $display("FAIL dw_aw got mgr %0d addr %h want mgr %0d addr 100", gid, aw_addr, e.mgr);
    end
    checks++;
    if (wv_early !== 1'b0) begin
      errors++; $display("FAIL dw_wvalid_early got %b want 0", wv_early);
    end
    checks++;
    if (wdata !== e.data) begin
      errors++; $display("FAIL dw_wdata got %h want %h", wdata, e.data);
    end
    checks++;
    if (bmask !== 4'b0010) begin
      errors++; $display("FAIL dw_b_route got %b want 0010", bmask);
    end
  endtask

  task automatic test_concurrent();
    clear_inputs();
    i_axi_m_arvalid[2] = 1'b1;
    i_axi_m_awvalid[3] = 1'b1;
    exp_q.push_back('{3, wr_data(3)});
    step();
    checks++;
    if ({o_axi_s_arvalid, o_axi_s_awvalid} !== 2'b11) begin
      errors++; $display("FAIL cc_both_valid got %b want 11", {o_axi_s_arvalid, o_axi_s_awvalid});
    end
    checks++;
    if (o_axi_s_ar.addr !== 32'h2020 || o_axi_s_aw.addr !== 32'h1030) begin
      errors++; $display("FAIL cc_addr got ar %h aw %h want 2020/1030", o_axi_s_ar.addr, o_axi_s_aw.addr);
    end
    i_axi_s_arready = 1'b1; i_axi_s_awready = 1'b1;
    step();
    i_axi_s_arready = 1'b0; i_axi_s_awready = 1'b0;
    i_axi_m_arvalid = '0; i_axi_m_awvalid = '0;
    i_axi_m_wvalid[3] = 1'b1; i_axi_s_wready = 1'b1;
    i_axi_s_r.id = 4'd2; i_axi_s_r.data = rd_data(2); i_axi_s_r.last = 1'b1;
    i_axi_s_rvalid = 1'b1; i_axi_m_rready = '1;
    #1;
    checks++;
    if (o_axi_m_rvalid !== 4'b0100 || o_axi_m_r[2].id !== 4'd2 || o_axi_s_w.data !== exp_q[0].data) begin
      errors++; $display("FAIL cc_r_route got %b id %0d wdata %h want 0100 id 2", o_axi_m_rvalid, o_axi_m_r[2].id, o_axi_s_w.data);
    end
    step();
    i_axi_m_wvalid = '0; i_axi_s_wready = 1'b0;
    i_axi_s_rvalid = 1'b0; i_axi_m_rready = '0;
    i_axi_s_b.id = 4'd3; i_axi_s_bvalid = 1'b1; i_axi_m_bready = '1;
    #1;
    checks++;
    if (exp_q.size() == 0 || o_axi_m_bvalid !== 4'(1 << exp_q[0].mgr) || o_axi_m_b[3].id !== 4'd3) begin
      errors++; $display("FAIL cc_b_route got %b id %0d want 1000 id 3", o_axi_m_bvalid, o_axi_m_b[3].id);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    step();
    i_axi_s_bvalid = 1'b0; i_axi_m_bready = '0;
  endtask

  task automatic test_backpressure();
    axi_aw_t cap;
    int n, hs, extra;
    clear_inputs();
    i_axi_m_aw[2].addr = 32'h0000_0200;
    i_axi_m_awvalid[2] = 1'b1;
    n = 0;
    #1;
    while (!o_axi_s_awvalid && n < 10) begin
      step(); #1; n++;
    end
    checks++;
    if (!o_axi_s_awvalid) begin
      errors++; $display("FAIL bp_aw_timeout got 0 want 1");
      clear_inputs();
      return;
    end
    cap = o_axi_s_aw;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (o_axi_s_awvalid !== 1'b1 || o_axi_s_aw !== cap) begin
        errors++; $display("FAIL bp_aw_stable got %b/%h want 1/%h", o_axi_s_awvalid, o_axi_s_aw, cap);
      end
    end
    i_axi_s_awready = 1'b1;
    #1;
    checks++;
    if (o_axi_m_awready !== 4'b0100) begin
      errors++; $display("FAIL bp_awready got %b want 0100", o_axi_m_awready);
    end
    step();
    i_axi_s_awready = 1'b0; i_axi_m_awvalid = '0;
    i_axi_m_wvalid[2] = 1'b1; i_axi_s_wready = 1'b1;
    step();
    i_axi_m_wvalid = '0; i_axi_s_wready = 1'b0;
    i_axi_s_b.id = 4'd2; i_axi_s_bvalid = 1'b1;
    hs = 0; extra = 0;
    for (int c = 0; c < 30; c++) begin
      i_axi_m_bready[2] = (c >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if ((o_axi_m_bvalid & 4'b1011) != 4'b0000) extra++;
      if (o_axi_m_bvalid[2] && i_axi_m_bready[2]) begin
        hs++;
        step();
        i_axi_s_bvalid = 1'b0;
      end else begin
        step();
      end
    end
    i_axi_m_bready = '0; i_axi_s_bvalid = 1'b0;
    checks++;
    if (hs !== 1 || extra !== 0) begin
      errors++; $display("FAIL bp_b_count got %0d (stray %0d) want 1 (stray 0)", hs, extra);
    end
  endtask

  task automatic test_reset_mid();
    int gid, lat, n;
    logic [31:0] aw_addr;
    logic [3:0] awr_mask, bmask, bid;
    logic wv_early, tmo;
    logic [63:0] wdata;
    exp_t e;
    clear_inputs();
    i_axi_m_awvalid[1] = 1'b1;
    n = 0;
    #1;
    while (!o_axi_s_awvalid && n < 10) begin
      step(); #1; n++;
    end
    i_axi_s_awready = 1'b1;
    step();
    i_axi_s_awready = 1'b0; i_axi_m_awvalid = '0;
    i_axi_m_wvalid[1] = 1'b1; i_axi_s_wready = 1'b1;
    i_axi_m_w[1].last = 1'b0;
    #1;
    checks++;
    if (o_axi_s_wvalid !== 1'b1) begin
      errors++; $display("FAIL mid_in_wdata got %b want 1", o_axi_s_wvalid);
    end
    rst = 1'b1;
    step();
    checks++;
    if (any_vr() !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %b want 0", any_vr());
    end
    rst = 1'b0;
    clear_inputs();
    i_axi_m_awvalid = 4'b0011;
    exp_q.push_back('{0, wr_data(0)});
    exp_q.push_back('{1, wr_data(1)});
    for (int i = 0; i < 2; i++) begin
      serve_write(0, gid, lat, aw_addr, awr_mask, wv_early, wdata, bmask, bid, tmo);
      e = exp_q.pop_front();
      checks++;
      if (tmo || gid !== e.mgr || wdata !== e.data || bmask !== 4'(1 << e.mgr)) begin
        errors++; $display("FAIL mid_after_reset got mgr %0d data %h b %b want mgr %0d data %h", gid, wdata, bmask, e.mgr, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_delayed_w();
    test_concurrent();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
